// File: rtl/fpu_pkg.sv
// Shared FPU datapath definitions: operation encoding and the mantissa add/sub result record.
package fpu_pkg;

    localparam int unsigned MANT_W_DEF = 28;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic                  carry;
        logic [MANT_W_DEF-1:0] mag;
        logic                  sign;
        logic                  zero;
        logic                  eff_sub;
    } addsub_res_t;

endpackage

// File: rtl/mant_addsub_core.sv
// Combinational mantissa add/sub with magnitude ordering and result-sign selection.
module mant_addsub_core
    import fpu_pkg::*;
#(
    parameter int  MANT_W = MANT_W_DEF,
    parameter type res_t  = addsub_res_t
) (
    input  logic [MANT_W-1:0] a,
    input  logic [MANT_W-1:0] b,
    input  logic              sign_a,
    input  logic              sign_b_eff,
    input  logic              eff_sub,
    input  logic              a_ge_b,
    input  logic              rm_down,
    output res_t              res
);

    logic [MANT_W:0]   sum;
    logic [MANT_W-1:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = a_ge_b ? (a - b) : (b - a);

    always_comb begin
        res         = '0;
        res.eff_sub = eff_sub;
        if (!eff_sub) begin
            res.carry = sum[MANT_W];
            res.mag   = sum[MANT_W-1:0];
            res.sign  = sign_a;
        end else begin
            res.carry = 1'b0;
            res.mag   = diff;
            // Exact cancellation takes its sign from the rounding mode, not the operands.
            if (diff == '0)
                res.sign = rm_down;
            else if (a_ge_b)
                res.sign = sign_a;
            else
                res.sign = sign_b_eff;
        end
        res.zero = !res.carry && (res.mag == '0);
    end

endmodule

// File: rtl/mant_addsub_pipe.sv
// Pipelined mantissa add/sub stage with valid/ready handshakes, bubble-collapsing stages and a tag.
module mant_addsub_pipe
    import fpu_pkg::*;
#(
    parameter int MANT_W      = MANT_W_DEF,
    parameter int PIPE_STAGES = 2,
    parameter int TAG_W       = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MANT_W-1:0] mantA,
    input  logic [MANT_W-1:0] mantB,
    input  logic              signA,
    input  logic              signB,
    input  logic              op,
    input  logic              rm_down,
    input  logic [TAG_W-1:0]  tag_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MANT_W:0]   mant_raw,
    output logic              sign_result,
    output logic              carry_out,
    output logic              is_zero,
    output logic              eff_sub,
    output logic [TAG_W-1:0]  tag_out
);

    localparam int unsigned P    = PIPE_STAGES;
    localparam bit          OPST = (PIPE_STAGES >= 2);
    localparam int unsigned R0   = OPST ? 1 : 0;
    localparam int unsigned NRES = P - R0;

    typedef struct packed {
        logic              carry;
        logic [MANT_W-1:0] mag;
        logic              sign;
        logic              zero;
        logic              eff_sub;
    } res_t;

    typedef struct packed {
        res_t             res;
        logic [TAG_W-1:0] tag;
    } out_t;

    typedef struct packed {
        logic [MANT_W-1:0] a;
        logic [MANT_W-1:0] b;
        logic              sign_a;
        logic              sign_b_eff;
        logic              eff_sub;
        logic              a_ge_b;
        logic              rm_down;
        logic [TAG_W-1:0]  tag;
    } opnd_t;

    logic [P-1:0] v;
    logic [P-1:0] rdy;
    logic [P-1:0] vin;
    opnd_t        opnd_in;
    opnd_t        core_opnd;
    res_t         core_res;
    out_t         res_q  [NRES];
    out_t         res_in [NRES];

    // Ready ripples back from the output so an empty slot anywhere lets upstream advance.
    always_comb begin
        rdy        = '0;
        vin        = '0;
        rdy[P-1]   = !v[P-1] || out_ready;
        for (int unsigned i = 1; i < P; i++)
            rdy[P-1-i] = !v[P-1-i] || rdy[P-i];
        vin[0] = in_valid;
        for (int unsigned i = 1; i < P; i++)
            vin[i] = v[i-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v <= '0;
        end else begin
            for (int unsigned i = 0; i < P; i++)
                if (rdy[i])
                    v[i] <= vin[i];
        end
    end

    always_comb begin
        opnd_in            = '0;
        opnd_in.a          = mantA;
        opnd_in.b          = mantB;
        opnd_in.sign_a     = signA;
        opnd_in.sign_b_eff = signB ^ (op == OP_SUB);
        opnd_in.eff_sub    = signA ^ opnd_in.sign_b_eff;
        opnd_in.a_ge_b     = (mantA >= mantB);
        opnd_in.rm_down    = rm_down;
        opnd_in.tag        = tag_in;
    end

    generate
        if (OPST) begin : g_opnd_reg
            opnd_t op_q;
            always_ff @(posedge clk) begin
                if (rst)
                    op_q <= '0;
                else if (rdy[0] && in_valid)
                    op_q <= opnd_in;
            end
            assign core_opnd = op_q;
        end else begin : g_opnd_pass
            assign core_opnd = opnd_in;
        end
    endgenerate

    mant_addsub_core #(
        .MANT_W (MANT_W),
        .res_t  (res_t)
    ) u_core (
        .a          (core_opnd.a),
        .b          (core_opnd.b),
        .sign_a     (core_opnd.sign_a),
        .sign_b_eff (core_opnd.sign_b_eff),
        .eff_sub    (core_opnd.eff_sub),
        .a_ge_b     (core_opnd.a_ge_b),
        .rm_down    (core_opnd.rm_down),
        .res        (core_res)
    );

    always_comb begin
        res_in[0] = '{res: core_res, tag: core_opnd.tag};
        for (int unsigned j = 1; j < NRES; j++)
            res_in[j] = res_q[j-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned j = 0; j < NRES; j++)
                res_q[j] <= '0;
        end else begin
            for (int unsigned j = 0; j < NRES; j++)
                if (rdy[R0+j] && vin[R0+j])
                    res_q[j] <= res_in[j];
        end
    end

    assign in_ready    = rdy[0];
    assign out_valid   = v[P-1];
    assign mant_raw    = {res_q[NRES-1].res.carry, res_q[NRES-1].res.mag};
    assign carry_out   = res_q[NRES-1].res.carry;
    assign sign_result = res_q[NRES-1].res.sign;
    assign is_zero     = res_q[NRES-1].res.zero;
    assign eff_sub     = res_q[NRES-1].res.eff_sub;
    assign tag_out     = res_q[NRES-1].tag;

endmodule

// File: tb/tb_mant_addsub_pipe.sv
// Directed bench for mant_addsub_pipe: arithmetic cases, back-pressure and mid-stream reset.
module tb_mant_addsub_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [27:0] mantA = '0;
    logic [27:0] mantB = '0;
    logic        signA = 1'b0;
    logic        signB = 1'b0;
    logic        op = 1'b0;
    logic        rm_down = 1'b0;
    logic [3:0]  tag_in = '0;
    logic        out_ready = 1'b1;

    logic        o2_in_ready, o2_out_valid, o2_sign, o2_carry, o2_zero, o2_eff;
    logic [28:0] o2_mant;
    logic [3:0]  o2_tag;
    logic        o1_in_ready, o1_out_valid, o1_sign, o1_carry, o1_zero, o1_eff;
    logic [28:0] o1_mant;
    logic [3:0]  o1_tag;
    logic        o3_in_ready, o3_out_valid, o3_sign, o3_carry, o3_zero, o3_eff;
    logic [28:0] o3_mant;
    logic [3:0]  o3_tag;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mant_addsub_pipe #(.MANT_W(28), .PIPE_STAGES(2), .TAG_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o2_in_ready),
        .mantA(mantA), .mantB(mantB), .signA(signA), .signB(signB), .op(op),
        .rm_down(rm_down), .tag_in(tag_in), .out_valid(o2_out_valid), .out_ready(out_ready),
        .mant_raw(o2_mant), .sign_result(o2_sign), .carry_out(o2_carry), .is_zero(o2_zero),
        .eff_sub(o2_eff), .tag_out(o2_tag)
    );

    mant_addsub_pipe #(.MANT_W(28), .PIPE_STAGES(1), .TAG_W(4)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o1_in_ready),
        .mantA(mantA), .mantB(mantB), .signA(signA), .signB(signB), .op(op),
        .rm_down(rm_down), .tag_in(tag_in), .out_valid(o1_out_valid), .out_ready(out_ready),
        .mant_raw(o1_mant), .sign_result(o1_sign), .carry_out(o1_carry), .is_zero(o1_zero),
        .eff_sub(o1_eff), .tag_out(o1_tag)
    );

    mant_addsub_pipe #(.MANT_W(28), .PIPE_STAGES(3), .TAG_W(4)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o3_in_ready),
        .mantA(mantA), .mantB(mantB), .signA(signA), .signB(signB), .op(op),
        .rm_down(rm_down), .tag_in(tag_in), .out_valid(o3_out_valid), .out_ready(out_ready),
        .mant_raw(o3_mant), .sign_result(o3_sign), .carry_out(o3_carry), .is_zero(o3_zero),
        .eff_sub(o3_eff), .tag_out(o3_tag)
    );

    // Presents one operation, then waits (bounded) until the 2-stage DUT shows its result.
    task automatic send(input logic [27:0] a, input logic [27:0] b, input logic sa,
                        input logic sb, input logic o, input logic rm, input logic [3:0] t,
                        output int lat);
        @(posedge clk); #1;
        mantA = a; mantB = b; signA = sa; signB = sb; op = o; rm_down = rm; tag_in = t;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!o2_out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        n_cmp++;
        if (o2_out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout: out_valid=%b after %0d cycles, required 1", o2_out_valid, lat);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (o2_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", o2_out_valid); end
        n_cmp++; if (o2_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", o2_in_ready); end
        n_cmp++; if (o2_mant !== 29'h0) begin n_fail++; $display("FAIL reset_mant: got %h want 0", o2_mant); end
        n_cmp++; if ({o2_sign, o2_carry, o2_zero, o2_eff, o2_tag} !== 8'h00) begin
            n_fail++; $display("FAIL reset_flags: got %b want 00000000", {o2_sign, o2_carry, o2_zero, o2_eff, o2_tag});
        end
    endtask

    task automatic test_add;
        int lat;
        send(28'h4000000, 28'h2000000, 1'b0, 1'b0, 1'b0, 1'b0, 4'h3, lat);
        n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL add_latency: got %0d want 2", lat); end
        n_cmp++; if (o2_mant !== 29'h06000000) begin n_fail++; $display("FAIL add_mant: got %h want 06000000", o2_mant); end
        n_cmp++; if ({o2_sign, o2_carry, o2_eff, o2_zero} !== 4'b0000) begin
            n_fail++; $display("FAIL add_flags: got %b want 0000", {o2_sign, o2_carry, o2_eff, o2_zero});
        end
        n_cmp++; if (o2_tag !== 4'h3) begin n_fail++; $display("FAIL add_tag: got %h want 3", o2_tag); end
    endtask

    task automatic test_carry;
        int lat;
        send(28'hFFFFFFF, 28'hFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 4'h5, lat);
        n_cmp++; if (o2_mant !== 29'h1FFFFFFE) begin n_fail++; $display("FAIL carry_mant: got %h want 1FFFFFFE", o2_mant); end
        n_cmp++; if (o2_carry !== 1'b1) begin n_fail++; $display("FAIL carry_out: got %b want 1", o2_carry); end
        n_cmp++; if (o2_eff !== 1'b0) begin n_fail++; $display("FAIL carry_eff_sub: got %b want 0", o2_eff); end
    endtask

    task automatic test_sub;
        int lat;
        send(28'h1000000, 28'h3000000, 1'b0, 1'b0, 1'b1, 1'b0, 4'h6, lat);
        n_cmp++; if (o2_mant !== 29'h02000000) begin n_fail++; $display("FAIL sub_mant: got %h want 02000000", o2_mant); end
        n_cmp++; if ({o2_sign, o2_eff, o2_carry} !== 3'b110) begin
            n_fail++; $display("FAIL sub_flags: got %b want 110", {o2_sign, o2_eff, o2_carry});
        end
        // -A + -B is an effective add carrying the sign of A
        send(28'h3000000, 28'h1000000, 1'b1, 1'b1, 1'b0, 1'b0, 4'h7, lat);
        n_cmp++; if ({o2_mant, o2_sign, o2_eff} !== {29'h04000000, 2'b10}) begin
            n_fail++; $display("FAIL neg_add: got %h/%b want 04000000/10", o2_mant, {o2_sign, o2_eff});
        end
        // -A + +B with A > B: effective subtract, sign of A
        send(28'h3000000, 28'h1000000, 1'b1, 1'b0, 1'b0, 1'b0, 4'h8, lat);
        n_cmp++; if ({o2_mant, o2_sign, o2_eff} !== {29'h02000000, 2'b11}) begin
            n_fail++; $display("FAIL mixed_sub: got %h/%b want 02000000/11", o2_mant, {o2_sign, o2_eff});
        end
    endtask

    task automatic test_cancel;
        int lat;
        send(28'h5555555, 28'h5555555, 1'b0, 1'b0, 1'b1, 1'b0, 4'h9, lat);
        n_cmp++; if ({o2_mant, o2_zero, o2_sign} !== {29'h0, 2'b10}) begin
            n_fail++; $display("FAIL cancel_rne: got %h/%b want 00000000/10", o2_mant, {o2_zero, o2_sign});
        end
        send(28'h5555555, 28'h5555555, 1'b0, 1'b0, 1'b1, 1'b1, 4'hA, lat);
        n_cmp++; if ({o2_mant, o2_zero, o2_sign} !== {29'h0, 2'b11}) begin
            n_fail++; $display("FAIL cancel_rdn: got %h/%b want 00000000/11", o2_mant, {o2_zero, o2_sign});
        end
        send(28'h0, 28'h0, 1'b1, 1'b1, 1'b0, 1'b0, 4'hB, lat);
        n_cmp++; if ({o2_zero, o2_sign, o2_eff} !== 3'b110) begin
            n_fail++; $display("FAIL neg_zero_add: got %b want 110", {o2_zero, o2_sign, o2_eff});
        end
    endtask

    task automatic test_backpressure;
        logic [27:0] va [6];
        logic [27:0] vb [6];
        logic [2:0]  vs [6];
        logic        vr [6];
        logic [28:0] em [6];
        logic        es [6];
        logic [28:0] held;
        logic [3:0]  held_tag;
        logic        have_held = 1'b0;
        logic        accepting = 1'b0;
        int          acc = 0;
        int          nout = 0;
        int          first_out = 0;
        int          last_out = 0;
        va = '{28'h0000010, 28'h0000010, 28'h0000001, 28'h8000000, 28'h0000100, 28'h1234567};
        vb = '{28'h0000001, 28'h0000001, 28'h0000010, 28'h8000000, 28'h0000100, 28'h0000567};
        vs = '{3'b000, 3'b001, 3'b100, 3'b000, 3'b111, 3'b010}; // {signA, signB, op}
        vr = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        em = '{29'h11, 29'hF, 29'hF, 29'h10000000, 29'h0, 29'h1234000};
        es = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int cyc = 0; cyc < 40 && nout < 6; cyc++) begin
            @(posedge clk); #1;
            if (accepting) acc++;
            if (cyc == 5) begin
                n_cmp++; if (acc !== 2) begin n_fail++; $display("FAIL bp_accepted: got %0d want 2", acc); end
            end
            out_ready = (cyc >= 5);
            in_valid  = (acc < 6);
            if (acc < 6) begin
                mantA = va[acc]; mantB = vb[acc];
                {signA, signB, op} = vs[acc];
                rm_down = vr[acc]; tag_in = 4'(acc + 1);
            end
            @(negedge clk);
            accepting = in_valid && o2_in_ready;
            if (cyc >= 2 && cyc <= 4) begin
                n_cmp++; if (o2_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready c%0d: got %b want 0", cyc, o2_in_ready); end
            end
            if (cyc < 5 && o2_out_valid) begin
                if (!have_held) begin
                    held = o2_mant; held_tag = o2_tag; have_held = 1'b1;
                end else begin
                    n_cmp++; if ({o2_mant, o2_tag} !== {held, held_tag}) begin
                        n_fail++; $display("FAIL bp_stable c%0d: got %h/%h want %h/%h", cyc, o2_mant, o2_tag, held, held_tag);
                    end
                end
            end
            if (o2_out_valid && out_ready) begin
                n_cmp++; if ({o2_mant, o2_sign, o2_tag} !== {em[nout], es[nout], 4'(nout + 1)}) begin
                    n_fail++; $display("FAIL bp_result%0d: got %h/%b/%h want %h/%b/%h", nout,
                                       o2_mant, o2_sign, o2_tag, em[nout], es[nout], 4'(nout + 1));
                end
                if (nout == 0) first_out = cyc;
                last_out = cyc;
                nout++;
            end
        end
        in_valid = 1'b0;
        n_cmp++; if (nout !== 6) begin n_fail++; $display("FAIL bp_count: got %0d want 6", nout); end
        n_cmp++; if (last_out - first_out !== 5) begin
            n_fail++; $display("FAIL bp_throughput: span %0d cycles want 5", last_out - first_out);
        end
    endtask

    task automatic test_reset_midstream;
        @(posedge clk); #1;
        out_ready = 1'b1;
        mantA = 28'h0000100; mantB = 28'h0000001; {signA, signB, op} = 3'b000; tag_in = 4'hC;
        in_valid = 1'b1;
        @(posedge clk); #1;
        tag_in = 4'hD;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if ({o1_in_ready, o2_in_ready, o3_in_ready} !== 3'b111) begin
            n_fail++; $display("FAIL rst_in_ready: got %b want 111", {o1_in_ready, o2_in_ready, o3_in_ready});
        end
        n_cmp++; if (o3_mant !== 29'h0) begin n_fail++; $display("FAIL rst_data_p3: got %h want 0", o3_mant); end
        for (int c = 0; c < 5; c++) begin
            n_cmp++; if ({o1_out_valid, o2_out_valid, o3_out_valid} !== 3'b000) begin
                n_fail++; $display("FAIL rst_stale c%0d: got %b want 000", c, {o1_out_valid, o2_out_valid, o3_out_valid});
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_carry();
        test_sub();
        test_cancel();
        test_backpressure();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
